alu_accum_ctrl: RTL and testbench

//   Registered accumulator and run controller, placed directly downstream of the 4-bit ALU.
//   - Captures the ALU's 8-bit result for a programmed number of cycles.
//   - Feeds the low nibble of the held result back to the ALU's B operand.
//   - Presents the final value on a valid/ready output handshake.
//   - Turns the combinational ALU into an iterated accumulate/shift engine.

---
 rtl/alu_accum_ctrl_if.sv | 27 ++
 rtl/alu_accum_ctrl.sv | 96 +++++++++
 tb/tb_alu_accum_ctrl.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/alu_accum_ctrl_if.sv
// Bus between the accumulator/run controller and its neighbours: run control,
// ALU result input, B operand feedback and the valid/ready result handshake.
interface alu_accum_ctrl_if #(
    parameter int RES_W = 8,
    parameter int FB_W  = 4,
    parameter int CNT_W = 4
);
    logic             start;
    logic [CNT_W-1:0] iter_count;
    logic             clear;
    logic [RES_W-1:0] alu_result;
    logic [FB_W-1:0]  B_fb;
    logic [RES_W-1:0] result;
    logic             busy;
    logic             out_valid;
    logic             out_ready;

    modport master (
        output start, iter_count, clear, alu_result, out_ready,
        input  B_fb, result, busy, out_valid
    );

    modport slave (
        input  start, iter_count, clear, alu_result, out_ready,
        output B_fb, result, busy, out_valid
    );
endinterface

// File: rtl/alu_accum_ctrl.sv
// Accumulator and run controller that iterates an upstream combinational ALU:
// captures its result for a programmed number of cycles, feeding the low bits back as B.
module alu_accum_ctrl #(
    parameter int RES_W = 8,
    parameter int FB_W  = 4,
    parameter int CNT_W = 4
) (
    input  logic            clk,
    input  logic            srst,
    alu_accum_ctrl_if.slave bus
);
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           state_reg, state_next;
    logic [RES_W-1:0] result_reg, result_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic             busy_c;
    logic             out_valid_c;

    always_ff @(posedge clk) begin
        if (srst) begin
            state_reg  <= ST_IDLE;
            result_reg <= '0;
            cnt_reg    <= '0;
        end else begin
            state_reg  <= state_next;
            result_reg <= result_next;
            cnt_reg    <= cnt_next;
        end
    end

    // cnt counts remaining captures; the edge that sees cnt==1 does the last one.
    always_comb begin
        state_next  = state_reg;
        result_next = result_reg;
        cnt_next    = cnt_reg;
        case (state_reg)
            ST_IDLE: begin
                if (bus.clear) begin
                    result_next = '0;
                end else if (bus.start) begin
                    if (bus.iter_count == '0) begin
                        state_next = ST_DONE;
                    end else begin
                        cnt_next   = bus.iter_count;
                        state_next = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                result_next = bus.alu_result;
                cnt_next    = cnt_reg - CNT_W'(1);
                if (cnt_reg == CNT_W'(1)) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                if (bus.out_ready) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        busy_c      = 1'b0;
        out_valid_c = 1'b0;
        case (state_reg)
            ST_RUN:  busy_c = 1'b1;
            ST_DONE: begin
                busy_c      = 1'b1;
                out_valid_c = 1'b1;
            end
            default: begin
                busy_c      = 1'b0;
                out_valid_c = 1'b0;
            end
        endcase
    end

    assign bus.busy      = busy_c;
    assign bus.out_valid = out_valid_c;
    assign bus.result    = result_reg;

    // Feedback comes straight off the register so the ALU sees it in the same cycle.
    generate
        for (genvar gi = 0; gi < FB_W; gi++) begin : g_fb
            assign bus.B_fb[gi] = result_reg[gi];
        end
    endgenerate
endmodule

// File: tb/tb_alu_accum_ctrl.sv
// Directed bench: a behavioural 4-bit ALU closes the loop through B_fb; final
// results go through a scoreboard queue checked by an independent monitor.
module tb_alu_accum_ctrl;
    localparam int RES_W = 8;
    localparam int FB_W  = 4;
    localparam int CNT_W = 4;

    logic       clk  = 1'b0;
    logic       srst = 1'b1;
    logic [3:0] a_op = 4'd0;
    logic [1:0] fn   = 2'd0;

    int checks = 0;
    int errors = 0;
    logic [RES_W-1:0] exp_q[$];

    alu_accum_ctrl_if #(.RES_W(RES_W), .FB_W(FB_W), .CNT_W(CNT_W)) bus ();

    alu_accum_ctrl #(.RES_W(RES_W), .FB_W(FB_W), .CNT_W(CNT_W)) dut (
        .clk  (clk),
        .srst (srst),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] alu_model(input logic [3:0] a, input logic [1:0] f,
                                             input logic [3:0] b);
        case (f)
            2'd0:    return {4'b0, a} + {4'b0, b};
            2'd1:    return {4'b0, a} - {4'b0, b};
            2'd2:    return {4'b0, a & b};
            default: return {a, b};
        endcase
    endfunction

    assign bus.alu_result = alu_model(a_op, fn, bus.B_fb);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_outs(input string tag, input logic [7:0] res, input logic bsy,
                              input logic vld);
        check({tag, ".result"}, 32'(bus.result), 32'(res));
        check({tag, ".busy"}, 32'(bus.busy), 32'(bsy));
        check({tag, ".out_valid"}, 32'(bus.out_valid), 32'(vld));
        check({tag, ".B_fb"}, 32'(bus.B_fb), 32'(res[3:0]));
        $display("%0t %s result=0x%02h busy=%0b out_valid=%0b", $time, tag, bus.result,
                 bus.busy, bus.out_valid);
    endtask

    // Issue a start in IDLE; the expected final value goes to the scoreboard.
    task automatic issue_start(input logic [3:0] n, input logic [7:0] final_val);
        bus.start      = 1'b1;
        bus.iter_count = n;
        exp_q.push_back(final_val);
        step();
        bus.start = 1'b0;
    endtask

    task automatic handshake(input string tag);
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        check({tag, ".hs_valid"}, 32'(bus.out_valid), 32'd0);
        check({tag, ".hs_busy"}, 32'(bus.busy), 32'd0);
    endtask

    // Monitor: a transfer happens at the edge following a cycle with valid&ready.
    always @(negedge clk) begin
        if (!srst && bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_underflow actual=0x%02h required=none", bus.result);
            end else begin
                logic [7:0] e;
                e = exp_q.pop_front();
                check("sb_result", 32'(bus.result), 32'(e));
                $display("%0t SB result=0x%02h expected=0x%02h", $time, bus.result, e);
            end
        end
    end

    initial begin
        bus.start      = 1'b0;
        bus.iter_count = '0;
        bus.clear      = 1'b0;
        bus.out_ready  = 1'b0;

        step();
        step();
        check_outs("reset", 8'h00, 1'b0, 1'b0);
        srst = 1'b0;

        // 1: A=3 add N=4
        bus.clear = 1'b1;
        step();
        bus.clear = 1'b0;
        check_outs("t1.clear", 8'h00, 1'b0, 1'b0);
        a_op = 4'd3;
        fn   = 2'd0;
        issue_start(4'd4, 8'h0C);
        check_outs("t1.accept", 8'h00, 1'b1, 1'b0);
        step(); check_outs("t1.cap1", 8'h03, 1'b1, 1'b0);
        step(); check_outs("t1.cap2", 8'h06, 1'b1, 1'b0);
        step(); check_outs("t1.cap3", 8'h09, 1'b1, 1'b0);
        step(); check_outs("t1.cap4", 8'h0C, 1'b1, 1'b1);
        handshake("t1");

        // 2: from 0, A=9 add N=3
        bus.clear = 1'b1;
        step();
        bus.clear = 1'b0;
        a_op = 4'd9;
        issue_start(4'd3, 8'h0B);
        step(); check_outs("t2.cap1", 8'h09, 1'b1, 1'b0);
        step(); check_outs("t2.cap2", 8'h12, 1'b1, 1'b0);
        step(); check_outs("t2.cap3", 8'h0B, 1'b1, 1'b1);
        handshake("t2");

        // 3: N=0 goes straight to DONE with no capture
        issue_start(4'd0, 8'h0B);
        check_outs("t3.n0", 8'h0B, 1'b1, 1'b1);

        // 4: hold in DONE, then ready with start (start ignored)
        for (int i = 0; i < 5; i++) begin
            step();
            check_outs("t4.hold", 8'h0B, 1'b1, 1'b1);
        end
        bus.out_ready  = 1'b1;
        bus.start      = 1'b1;
        bus.iter_count = 4'd2;
        step();
        bus.out_ready = 1'b0;
        bus.start     = 1'b0;
        check_outs("t4.release", 8'h0B, 1'b0, 1'b0);
        step();
        check_outs("t4.start_ignored", 8'h0B, 1'b0, 1'b0);

        // 5: reset in the middle of a run
        a_op = 4'd3;
        bus.start      = 1'b1;
        bus.iter_count = 4'd4;
        step();
        bus.start = 1'b0;
        step(); check_outs("t5.cap1", 8'h0E, 1'b1, 1'b0);
        srst = 1'b1;
        step();
        srst = 1'b0;
        check_outs("t5.reset", 8'h00, 1'b0, 1'b0);

        // Counter boundary: N=15 gives exactly 15 captures
        a_op = 4'd1;
        issue_start(4'd15, 8'h0F);
        for (int i = 1; i < 15; i++) step();
        check_outs("n15.cap14", 8'h0E, 1'b1, 1'b0);
        step();
        check_outs("n15.cap15", 8'h0F, 1'b1, 1'b1);
        handshake("n15");

        // Full-width capture: 15+15 keeps the carry into the high nibble
        a_op = 4'hF;
        issue_start(4'd1, 8'h1E);
        step();
        check_outs("wide.cap", 8'h1E, 1'b1, 1'b1);
        handshake("wide");

        // 6: clear has priority over start in IDLE
        bus.clear      = 1'b1;
        bus.start      = 1'b1;
        bus.iter_count = 4'd3;
        step();
        bus.clear = 1'b0;
        bus.start = 1'b0;
        check_outs("t6.clear_start", 8'h00, 1'b0, 1'b0);

        // 6b: start/clear pulsed during RUN are ignored
        a_op = 4'd1;
        issue_start(4'd3, 8'h03);
        bus.start = 1'b1;
        bus.clear = 1'b1;
        bus.iter_count = 4'd9;
        step(); check_outs("t6.cap1", 8'h01, 1'b1, 1'b0);
        bus.start = 1'b0;
        bus.clear = 1'b0;
        step(); check_outs("t6.cap2", 8'h02, 1'b1, 1'b0);
        step(); check_outs("t6.cap3", 8'h03, 1'b1, 1'b1);
        handshake("t6");

        step();
        check("sb_leftover", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
